// File: rtl/led_mem_pkg.sv
// Shared types and constants for the frame-memory arbiter: flip sequencer
// states, command encodings and bank-bit placement.
package led_mem_pkg;

  typedef enum logic [1:0] {
    FLIP_IDLE  = 2'd0,
    FLIP_DRAIN = 2'd1,
    FLIP_SWAP  = 2'd2
  } flip_state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int DEFAULT_ADDRESS_WIDTH = 25;
  localparam int BANK_BIT              = DEFAULT_ADDRESS_WIDTH - 1;

  // Bank bit sits at the top of the full memory address.
  function automatic int bank_bit(input int address_width);
    return address_width - 1;
  endfunction

endpackage

// File: rtl/led_mem_arbiter_if.sv
// Bundle of requester, flip and memory-port signals around the arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface led_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 25
);
  logic                     wr_valid;
  logic [ADDRESS_WIDTH-2:0] wr_addr;
  logic [7:0]               wr_data;
  logic                     wr_ready;
  logic                     rd_valid;
  logic [ADDRESS_WIDTH-2:0] rd_addr;
  logic                     rd_ready;
  logic [7:0]               rd_data;
  logic                     rd_data_valid;
  logic                     flip_req;
  logic                     flip_done;
  logic                     frame_buffer_select;
  logic                     mem_cmd_valid;
  logic                     mem_cmd_wr;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [7:0]               mem_wdata;
  logic                     mem_cmd_ready;
  logic [7:0]               mem_rdata;
  logic                     mem_rdata_valid;
  logic                     err_underflow;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, flip_req,
           mem_cmd_ready, mem_rdata, mem_rdata_valid,
    output wr_ready, rd_ready, rd_data, rd_data_valid, flip_done,
           frame_buffer_select, mem_cmd_valid, mem_cmd_wr, mem_addr,
           mem_wdata, err_underflow
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, flip_req,
           mem_cmd_ready, mem_rdata, mem_rdata_valid,
    input  wr_ready, rd_ready, rd_data, rd_data_valid, flip_done,
           frame_buffer_select, mem_cmd_valid, mem_cmd_wr, mem_addr,
           mem_wdata, err_underflow
  );
endinterface

// File: rtl/led_mem_outstanding_ctr.sv
// Counts reads accepted by memory but not yet returned; flags a return that
// arrives with nothing outstanding (sticky until reset).
module led_mem_outstanding_ctr #(
  parameter int MAX_COUNT = 4,
  parameter int WIDTH     = 3
) (
  input  logic             clk_device,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] count_q;
  logic             underflow_q;

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      unique case ({inc_i, dec_i})
        2'b10: begin
          if (count_q != WIDTH'(MAX_COUNT)) begin
            count_q <= count_q + 1'b1;
          end
        end
        2'b01: begin
          if (count_q == '0) begin
            underflow_q <= 1'b1;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        2'b11: begin
          // An unmatched return alongside a new issue still leaves that new
          // read outstanding.
          if (count_q == '0) begin
            underflow_q <= 1'b1;
            count_q     <= WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign count_o     = count_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/led_mem_arbiter.sv
// Arbitrates host writes and scan-out reads onto the single frame-memory
// command port, tracks reads in flight and sequences front/back buffer flips.
module led_mem_arbiter
  import led_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 25,
  parameter int STARVE_LIMIT    = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic              clk_device,
  input logic              reset_n,
  led_mem_arbiter_if.slave bus
);

  localparam int BANK = bank_bit(ADDRESS_WIDTH);
  localparam int CW   = $clog2(MAX_OUTSTANDING + 2);
  localparam int SW   = 8;

  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_C  = SW'(STARVE_LIMIT);

  logic                     cmd_valid_q, cmd_valid_d;
  logic                     cmd_wr_q, cmd_wr_d;
  logic [ADDRESS_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]               cmd_wdata_q, cmd_wdata_d;
  logic [SW-1:0]            starve_q, starve_d;

  flip_state_e flip_state_q;
  logic        flip_pending_q;
  logic        flip_done_q;
  logic        fbs_q;

  logic [7:0] rd_data_q;
  logic       rd_data_valid_q;

  logic [CW-1:0] out_cnt;
  logic          underflow;

  logic load_en;
  logic rd_in_cmd;
  logic rd_eligible;
  logic wr_forced;
  logic wr_grant;
  logic rd_grant;
  logic rd_issue;

  // The output stage can take a new command when it is empty or draining now.
  assign load_en     = reset_n && (!cmd_valid_q || bus.mem_cmd_ready);
  assign rd_in_cmd   = cmd_valid_q && (cmd_wr_q == CMD_READ);
  assign rd_eligible = bus.rd_valid && !flip_pending_q
                       && ((out_cnt + CW'(rd_in_cmd)) < MAX_OUT_C);
  assign wr_forced   = (starve_q == STARVE_C);
  assign wr_grant    = load_en && bus.wr_valid && (!rd_eligible || wr_forced);
  assign rd_grant    = load_en && rd_eligible && !wr_grant;
  assign rd_issue    = rd_in_cmd && bus.mem_cmd_ready;

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (load_en) begin
      cmd_valid_d = wr_grant || rd_grant;
      if (wr_grant) begin
        cmd_wr_d               = CMD_WRITE;
        cmd_addr_d[BANK]       = ~fbs_q;
        cmd_addr_d[BANK-1:0]   = bus.wr_addr;
        cmd_wdata_d            = bus.wr_data;
      end else if (rd_grant) begin
        cmd_wr_d               = CMD_READ;
        cmd_addr_d[BANK]       = fbs_q;
        cmd_addr_d[BANK-1:0]   = bus.rd_addr;
        cmd_wdata_d            = 8'h00;
      end
    end
  end

  always_comb begin
    starve_d = '0;
    if (bus.wr_valid && !wr_grant) begin
      starve_d = (starve_q == STARVE_C) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid_q     <= 1'b0;
      cmd_wr_q        <= CMD_READ;
      cmd_addr_q      <= '0;
      cmd_wdata_q     <= '0;
      starve_q        <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      cmd_valid_q     <= cmd_valid_d;
      cmd_wr_q        <= cmd_wr_d;
      cmd_addr_q      <= cmd_addr_d;
      cmd_wdata_q     <= cmd_wdata_d;
      starve_q        <= starve_d;
      rd_data_q       <= bus.mem_rdata;
      rd_data_valid_q <= bus.mem_rdata_valid;
    end
  end

  // Flip waits until every read of the old bank has returned, so no read
  // ever straddles the bank change.
  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      flip_state_q   <= FLIP_IDLE;
      flip_pending_q <= 1'b0;
      flip_done_q    <= 1'b0;
      fbs_q          <= 1'b0;
    end else begin
      flip_done_q <= 1'b0;
      unique case (flip_state_q)
        FLIP_IDLE: begin
          if (bus.flip_req) begin
            flip_state_q   <= FLIP_DRAIN;
            flip_pending_q <= 1'b1;
          end
        end
        FLIP_DRAIN: begin
          if ((out_cnt == '0) && !rd_in_cmd) begin
            flip_state_q <= FLIP_SWAP;
          end
        end
        FLIP_SWAP: begin
          fbs_q          <= ~fbs_q;
          flip_done_q    <= 1'b1;
          flip_pending_q <= 1'b0;
          flip_state_q   <= FLIP_IDLE;
        end
        default: flip_state_q <= FLIP_IDLE;
      endcase
    end
  end

  led_mem_outstanding_ctr #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .WIDTH     (CW)
  ) u_outstanding (
    .clk_device  (clk_device),
    .reset_n     (reset_n),
    .inc_i       (rd_issue),
    .dec_i       (bus.mem_rdata_valid),
    .count_o     (out_cnt),
    .underflow_o (underflow)
  );

  assign bus.wr_ready            = wr_grant;
  assign bus.rd_ready            = rd_grant;
  assign bus.mem_cmd_valid       = cmd_valid_q;
  assign bus.mem_cmd_wr          = cmd_wr_q;
  assign bus.mem_addr            = cmd_addr_q;
  assign bus.mem_wdata           = cmd_wdata_q;
  assign bus.rd_data             = rd_data_q;
  assign bus.rd_data_valid       = rd_data_valid_q;
  assign bus.flip_done           = flip_done_q;
  assign bus.frame_buffer_select = fbs_q;
  assign bus.err_underflow       = underflow;

endmodule

// File: tb/tb_led_mem_arbiter.sv
// Bench for led_mem_arbiter: a vector table, directed multi-cycle sequences
// and a randomized run against a queue-based memory/arbitration model.
module tb_led_mem_arbiter;
  import led_mem_pkg::*;

  localparam int AW = 25;
  localparam int SL = 8;
  localparam int MO = 4;

  logic clk_device = 1'b0;
  logic reset_n    = 1'b0;
  always #5 clk_device = ~clk_device;

  led_mem_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();

  led_mem_arbiter #(
    .ADDRESS_WIDTH   (AW),
    .STARVE_LIMIT    (SL),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_device (clk_device),
    .reset_n    (reset_n),
    .bus        (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rv;
    logic        wv;
    logic [23:0] ra;
    logic [23:0] wa;
    logic [7:0]  wd;
    logic        e_wr_rdy;
    logic        e_rd_rdy;
    logic        e_cv;
    logic        e_cwr;
    logic [24:0] e_addr;
  } vec_t;

  vec_t vt [8];

  // Reference model state: output stage contents, reads held by memory,
  // consecutive stalled-write cycles, last return presented to the DUT.
  logic          m_sv, m_swr;
  logic [AW-1:0] m_sa;
  logic [7:0]    m_sd;
  int            m_starve;
  logic [AW-1:0] inflight_q [$];
  logic          p_rv;
  logic [7:0]    p_rd;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_valid        = 1'b0;
    bus.wr_addr         = '0;
    bus.wr_data         = '0;
    bus.rd_valid        = 1'b0;
    bus.rd_addr         = '0;
    bus.flip_req        = 1'b0;
    bus.mem_cmd_ready   = 1'b0;
    bus.mem_rdata       = '0;
    bus.mem_rdata_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk_device);
    @(negedge clk_device);
    reset_n = 1'b1;
  endtask

  initial begin
    int            grants;
    int            n_out;
    logic          found;
    logic          acc_prev;
    logic          rv, load_ok, elig, e_w, e_r;
    logic [AW-1:0] ret_a;

    vt[0] = '{1'b0, 1'b1, 24'h0,  24'h10, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 25'h1000010};
    vt[1] = '{1'b1, 1'b0, 24'h20, 24'h0,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 25'h0000020};
    vt[2] = '{1'b1, 1'b1, 24'h21, 24'h11, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 25'h0000021};
    vt[3] = '{1'b1, 1'b1, 24'h22, 24'h11, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 25'h0000022};
    vt[4] = '{1'b1, 1'b1, 24'h23, 24'h11, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 25'h0000023};
    vt[5] = '{1'b1, 1'b1, 24'h24, 24'h55, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 25'h1000055};
    vt[6] = '{1'b1, 1'b0, 24'h25, 24'h0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 25'h0};
    vt[7] = '{1'b0, 1'b0, 24'h0,  24'h0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 25'h0};

    // Reset state
    idle_inputs();
    #1;
    chk("rst_cmd_valid", bus.mem_cmd_valid, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_fbs", bus.frame_buffer_select, 0);
    chk("rst_flip_done", bus.flip_done, 0);
    chk("rst_err", bus.err_underflow, 0);
    chk("rst_rd_valid", bus.rd_data_valid, 0);

    // Vector table: consecutive cycles, no returns, memory always ready
    do_reset();
    bus.mem_cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rd_valid = vt[i].rv;
      bus.wr_valid = vt[i].wv;
      bus.rd_addr  = vt[i].ra;
      bus.wr_addr  = vt[i].wa;
      bus.wr_data  = vt[i].wd;
      #1;
      chk("vec_wr_ready", bus.wr_ready, vt[i].e_wr_rdy);
      chk("vec_rd_ready", bus.rd_ready, vt[i].e_rd_rdy);
      @(negedge clk_device);
      chk("vec_cmd_valid", bus.mem_cmd_valid, vt[i].e_cv);
      if (vt[i].e_cv) begin
        chk("vec_cmd_wr", bus.mem_cmd_wr, vt[i].e_cwr);
        chk("vec_cmd_addr", bus.mem_addr, vt[i].e_addr);
        if (vt[i].e_cwr) chk("vec_cmd_wdata", bus.mem_wdata, vt[i].wd);
      end
      $display("vec %0d: wr_ready=%0b rd_ready=%0b cmd_valid=%0b addr=%h", i,
               vt[i].e_wr_rdy, vt[i].e_rd_rdy, bus.mem_cmd_valid, bus.mem_addr);
    end

    // Back-pressure: loaded read held stable for 5 stalled cycles
    do_reset();
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 24'h123;
    #1;
    chk("bp_first_rd_ready", bus.rd_ready, 1);
    @(negedge clk_device);
    bus.rd_addr  = 24'h456;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 24'h1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rd_ready", bus.rd_ready, 0);
      chk("bp_wr_ready", bus.wr_ready, 0);
      chk("bp_cmd_valid", bus.mem_cmd_valid, 1);
      chk("bp_cmd_addr", bus.mem_addr, 25'h0000123);
      @(negedge clk_device);
    end
    bus.mem_cmd_ready = 1'b1;
    #1;
    chk("bp_release_addr", bus.mem_addr, 25'h0000123);
    chk("bp_release_rd_ready", bus.rd_ready, 1);
    @(negedge clk_device);
    chk("bp_next_addr", bus.mem_addr, 25'h0000456);
    chk("bp_next_wr", bus.mem_cmd_wr, CMD_READ);
    $display("backpressure: held 5 cycles, next addr=%h", bus.mem_addr);

    // Starvation: reads and writes both pending, reads returned promptly
    do_reset();
    bus.mem_cmd_ready = 1'b1;
    bus.rd_valid = 1'b1;
    bus.wr_valid = 1'b1;
    bus.rd_addr  = 24'h200;
    bus.wr_addr  = 24'h300;
    bus.wr_data  = 8'h5A;
    acc_prev = 1'b0;
    for (int c = 0; c < 19; c++) begin
      bus.mem_rdata_valid = acc_prev;
      bus.mem_rdata       = 8'(c);
      acc_prev = bus.mem_cmd_valid && (bus.mem_cmd_wr == CMD_READ);
      #1;
      chk("starve_wr_ready", bus.wr_ready, (c == 8 || c == 17));
      chk("starve_rd_ready", bus.rd_ready, !(c == 8 || c == 17));
      @(negedge clk_device);
    end
    $display("starvation: write granted after %0d reads, twice", SL);

    // Outstanding cap
    do_reset();
    bus.mem_cmd_ready = 1'b1;
    bus.rd_valid = 1'b1;
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.rd_ready) grants++;
      @(negedge clk_device);
    end
    chk("cap_grants", grants, MO);
    #1;
    chk("cap_rd_ready_low", bus.rd_ready, 0);
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 8'h3C;
    @(negedge clk_device);
    bus.mem_rdata_valid = 1'b0;
    chk("cap_ret_valid", bus.rd_data_valid, 1);
    chk("cap_ret_data", bus.rd_data, 8'h3C);
    grants = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.rd_ready) grants++;
      @(negedge clk_device);
    end
    chk("cap_regrant", grants, 1);
    $display("outstanding cap: %0d reads then one more after a return", MO);

    // Flip with two reads outstanding
    do_reset();
    bus.mem_cmd_ready = 1'b1;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 24'h30;
    #1;
    chk("flip_rd0_ready", bus.rd_ready, 1);
    @(negedge clk_device);
    bus.rd_addr = 24'h31;
    #1;
    chk("flip_rd1_ready", bus.rd_ready, 1);
    @(negedge clk_device);
    bus.rd_valid = 1'b0;
    @(negedge clk_device);
    bus.flip_req = 1'b1;
    @(negedge clk_device);
    bus.flip_req = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 24'h44;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 24'h77;
    bus.wr_data  = 8'h99;
    #1;
    chk("drain_rd_ready", bus.rd_ready, 0);
    chk("drain_wr_ready", bus.wr_ready, 1);
    @(negedge clk_device);
    chk("drain_wr_addr", bus.mem_addr, 25'h1000077);
    chk("drain_wr_cmd", bus.mem_cmd_wr, CMD_WRITE);
    bus.wr_valid        = 1'b0;
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 8'h01;
    #1;
    chk("drain_rd_ready_r1", bus.rd_ready, 0);
    @(negedge clk_device);
    bus.mem_rdata = 8'h02;
    #1;
    chk("drain_rd_ready_r2", bus.rd_ready, 0);
    @(negedge clk_device);
    bus.mem_rdata_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.flip_done) begin
        found = 1'b1;
        break;
      end
      chk("swap_rd_ready", bus.rd_ready, 0);
      @(negedge clk_device);
    end
    chk("flip_done_seen", found, 1);
    chk("flip_fbs", bus.frame_buffer_select, 1);
    chk("flip_rd_ready", bus.rd_ready, 1);
    @(negedge clk_device);
    bus.rd_valid = 1'b0;
    chk("flip_done_pulse", bus.flip_done, 0);
    chk("flip_rd_cmd", bus.mem_cmd_wr, CMD_READ);
    chk("flip_rd_addr", bus.mem_addr, 25'h1000044);
    $display("flip: select=%0b read addr=%h", bus.frame_buffer_select, bus.mem_addr);

    // Randomized run against the model
    do_reset();
    m_sv = 1'b0; m_swr = 1'b0; m_sa = '0; m_sd = '0; m_starve = 0;
    inflight_q.delete();
    p_rv = 1'b0; p_rd = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk("rnd_cmd_valid", bus.mem_cmd_valid, m_sv);
      if (m_sv) begin
        chk("rnd_cmd_wr", bus.mem_cmd_wr, m_swr);
        chk("rnd_cmd_addr", bus.mem_addr, m_sa);
        if (m_swr) chk("rnd_cmd_wdata", bus.mem_wdata, m_sd);
      end
      chk("rnd_rd_data_valid", bus.rd_data_valid, p_rv);
      if (p_rv) chk("rnd_rd_data", bus.rd_data, p_rd);

      n_out = inflight_q.size();
      bus.rd_valid      = ($urandom_range(0, 3) != 0);
      bus.wr_valid      = ($urandom_range(0, 1) != 0);
      bus.rd_addr       = (AW-1)'($urandom());
      bus.wr_addr       = (AW-1)'($urandom());
      bus.wr_data       = 8'($urandom());
      bus.mem_cmd_ready = ($urandom_range(0, 3) != 0);
      rv = (n_out > 0) && ($urandom_range(0, 2) == 0);
      if (rv) begin
        ret_a = inflight_q.pop_front();
        bus.mem_rdata = mem_byte(ret_a);
      end else begin
        bus.mem_rdata = 8'($urandom());
      end
      bus.mem_rdata_valid = rv;
      #1;

      load_ok = !m_sv || bus.mem_cmd_ready;
      elig    = bus.rd_valid && ((n_out + ((m_sv && !m_swr) ? 1 : 0)) < MO);
      e_w     = load_ok && bus.wr_valid && (!elig || m_starve == SL);
      e_r     = load_ok && elig && !e_w;
      chk("rnd_wr_ready", bus.wr_ready, e_w);
      chk("rnd_rd_ready", bus.rd_ready, e_r);

      if (m_sv && bus.mem_cmd_ready && !m_swr) inflight_q.push_back(m_sa);
      if (load_ok) begin
        m_sv = e_w || e_r;
        if (e_w) begin
          m_swr = 1'b1;
          m_sa  = {1'b1, bus.wr_addr};
          m_sd  = bus.wr_data;
        end else if (e_r) begin
          m_swr = 1'b0;
          m_sa  = {1'b0, bus.rd_addr};
        end
      end
      if (bus.wr_valid && !e_w) m_starve = (m_starve == SL) ? SL : m_starve + 1;
      else                      m_starve = 0;
      p_rv = rv;
      p_rd = bus.mem_rdata;
      @(negedge clk_device);
    end
    chk("rnd_no_underflow", bus.err_underflow, 0);
    $display("random: 2000 cycles, %0d reads still in memory", inflight_q.size());

    // Underflow: return with nothing outstanding, sticky until reset
    do_reset();
    #1;
    chk("uf_clear", bus.err_underflow, 0);
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 8'hEE;
    @(negedge clk_device);
    bus.mem_rdata_valid = 1'b0;
    #1;
    chk("uf_set", bus.err_underflow, 1);
    chk("uf_rd_data_valid", bus.rd_data_valid, 1);
    repeat (3) @(negedge clk_device);
    #1;
    chk("uf_sticky", bus.err_underflow, 1);
    reset_n = 1'b0;
    #1;
    chk("uf_reset_clear", bus.err_underflow, 0);
    $display("underflow: set, held, cleared by reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
